// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_pkg : size encodings, byte-enable / alignment helpers, request payload |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    // Payload is sized for the widest supported configuration so that every
    // parameterisation (and the next stage) can share one type.
    localparam int MEM_MAX_ADDR_W = 64;
    localparam int MEM_MAX_DATA_W = 64;
    localparam int MEM_MAX_LANES  = MEM_MAX_DATA_W / 8;
    localparam int MEM_MAX_REG_W  = 8;

    typedef struct packed {
        logic                      readmem;
        logic                      writemem;
        logic [MEM_MAX_ADDR_W-1:0] data_addr;
        logic [MEM_MAX_LANES-1:0]  byte_en;
        logic [MEM_MAX_DATA_W-1:0] storedata;
        logic [1:0]                size;
        logic [MEM_MAX_REG_W-1:0]  regdest;
        logic                      writereg;
        logic                      misaligned;
    } mem_req_t;

    function automatic logic [MEM_MAX_LANES-1:0] calc_byte_en(input logic [1:0] size,
                                                               input logic [2:0] lane);
        logic [MEM_MAX_LANES-1:0] ones;
        case (size)
            SIZE_BYTE: ones = 8'h01;
            SIZE_HALF: ones = 8'h03;
            SIZE_WORD: ones = 8'h0F;
            default:   ones = 8'hFF;
        endcase
        return ones << lane;
    endfunction

    // dword_ok is low on 32-bit datapaths, where a dword access is illegal.
    function automatic logic calc_misaligned(input logic [1:0] size,
                                             input logic [2:0] addr_lo,
                                             input logic       dword_ok);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo[1:0];
            default:   bad = !dword_ok || (|addr_lo);
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_agen_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_agen_if : upstream and downstream handshake/payload bundle            |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
interface mem_agen_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
);
    localparam int LANES = DATA_W / 8;

    logic              in_valid;
    logic              in_ready;
    logic              in_readmem;
    logic              in_writemem;
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] in_offset;
    logic [DATA_W-1:0] in_storedata;
    logic [1:0]        in_size;
    logic [REG_W-1:0]  in_regdest;
    logic              in_writereg;

    logic              out_valid;
    logic              out_ready;
    logic              out_readmem;
    logic              out_writemem;
    logic [ADDR_W-1:0] out_data_addr;
    logic [LANES-1:0]  out_byte_en;
    logic [DATA_W-1:0] out_storedata;
    logic [1:0]        out_size;
    logic [REG_W-1:0]  out_regdest;
    logic              out_writereg;
    logic              out_misaligned;

    modport master (
        output in_valid, in_readmem, in_writemem, in_base, in_offset,
               in_storedata, in_size, in_regdest, in_writereg, out_ready,
        input  in_ready, out_valid, out_readmem, out_writemem, out_data_addr,
               out_byte_en, out_storedata, out_size, out_regdest, out_writereg,
               out_misaligned
    );

    modport slave (
        input  in_valid, in_readmem, in_writemem, in_base, in_offset,
               in_storedata, in_size, in_regdest, in_writereg, out_ready,
        output in_ready, out_valid, out_readmem, out_writemem, out_data_addr,
               out_byte_en, out_storedata, out_size, out_regdest, out_writereg,
               out_misaligned
    );
endinterface
`default_nettype wire

// File: rtl/mem_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_skid_buf : generic one-entry-skid valid/ready pipeline register       |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_skid_buf #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_valid;
    logic         skid_valid;
    logic         ready_q;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         main_free;

    assign accept    = in_valid & ready_q;
    assign main_free = ~main_valid | out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (main_free) begin
            // Skid drains first; ready_q was low, so no accept can collide with it.
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
            ready_q <= 1'b1;
        end else begin
            if (accept) begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
            ready_q <= ~(skid_valid | accept);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : '0;

endmodule
`default_nettype wire

// File: rtl/mem_agen_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_agen_stage : effective address, byte enables, store alignment, skid   |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_agen_stage
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      flush,
    mem_agen_if.slave bus
);
    localparam int LANES = DATA_W / 8;

    logic [ADDR_W-1:0] eff_addr;
    logic [2:0]        lane;
    logic              is_mem;
    logic              bad;
    logic [DATA_W-1:0] storedata_sh;
    mem_req_t          req;
    mem_req_t          resp;
    logic              unused_resp_bits;

    assign eff_addr = bus.in_base + bus.in_offset;
    assign lane     = (DATA_W == 64) ? eff_addr[2:0] : {1'b0, eff_addr[1:0]};
    assign is_mem   = bus.in_readmem | bus.in_writemem;

    // A load+store combination is rejected irrespective of alignment.
    assign bad = (bus.in_readmem & bus.in_writemem)
               | (is_mem & calc_misaligned(bus.in_size, eff_addr[2:0], DATA_W == 64));

    assign storedata_sh = bus.in_storedata << {lane, 3'b000};

    always_comb begin
        req                           = '0;
        req.readmem                   = bus.in_readmem & ~bad;
        req.writemem                  = bus.in_writemem & ~bad;
        req.data_addr[ADDR_W-1:0]     = eff_addr;
        req.byte_en                   = (is_mem & ~bad) ? calc_byte_en(bus.in_size, lane) : '0;
        req.storedata[DATA_W-1:0]     = storedata_sh;
        req.size                      = bus.in_size;
        req.regdest[REG_W-1:0]        = bus.in_regdest;
        req.writereg                  = bus.in_writereg & ~bad;
        req.misaligned                = bad;
    end

    mem_skid_buf #(
        .W($bits(mem_req_t))
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (bus.in_valid),
        .in_ready (bus.in_ready),
        .in_data  (req),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .out_data (resp)
    );

    assign bus.out_readmem    = resp.readmem;
    assign bus.out_writemem   = resp.writemem;
    assign bus.out_data_addr  = resp.data_addr[ADDR_W-1:0];
    assign bus.out_byte_en    = resp.byte_en[LANES-1:0];
    assign bus.out_storedata  = resp.storedata[DATA_W-1:0];
    assign bus.out_size       = resp.size;
    assign bus.out_regdest    = resp.regdest[REG_W-1:0];
    assign bus.out_writereg   = resp.writereg;
    assign bus.out_misaligned = resp.misaligned;

    // Padding bits of the shared payload above this configuration's widths.
    assign unused_resp_bits = ^{resp.data_addr, resp.byte_en, resp.storedata, resp.regdest};

endmodule
`default_nettype wire

// File: tb/tb_mem_agen_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_agen_stage : directed + random stimulus against a queue model      |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mem_agen_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] sd;
        logic [1:0]  size;
        logic [4:0]  dest;
        logic        rdm;
        logic        wrm;
        logic        wreg;
        logic        mis;
    } exp_t;

    logic clock;
    logic reset;
    logic flush;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    bit   ready_m;

    mem_agen_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

    mem_agen_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: computed straight from the address/size rules with integers.
    function automatic exp_t model_txn();
        exp_t        e;
        logic [31:0] a;
        int          nbytes;
        int          lane;
        bit          is_mem;
        bit          bad;
        logic [31:0] shifted;
        a       = bus.in_base + bus.in_offset;
        nbytes  = 1 << bus.in_size;
        lane    = int'(a % 4);
        is_mem  = bus.in_readmem || bus.in_writemem;
        bad     = (bus.in_readmem && bus.in_writemem) ||
                  (is_mem && (bus.in_size == 2'd3 || (a % nbytes) != 0));
        shifted = bus.in_storedata << (8 * lane);
        e.addr  = a;
        e.be    = (is_mem && !bad) ? 4'(((1 << nbytes) - 1) << lane) : 4'd0;
        e.sd    = shifted;
        e.size  = bus.in_size;
        e.dest  = bus.in_regdest;
        e.rdm   = bus.in_readmem && !bad;
        e.wrm   = bus.in_writemem && !bad;
        e.wreg  = bus.in_writereg && !bad;
        e.mis   = bad;
        return e;
    endfunction

    task automatic model_edge();
        bit acc;
        if (reset) begin
            q.delete();
            ready_m = 1'b0;
        end else if (flush) begin
            q.delete();
            ready_m = 1'b1;
        end else begin
            acc = bus.in_valid && ready_m;
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (acc) q.push_back(model_txn());
            ready_m = (q.size() < 2);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        e = '{default: '0};
        if (q.size() > 0) e = q[0];
        check_val("in_ready",   bus.in_ready,       ready_m);
        check_val("out_valid",  bus.out_valid,      q.size() > 0);
        check_val("addr",       bus.out_data_addr,  e.addr);
        check_val("byte_en",    bus.out_byte_en,    e.be);
        check_val("storedata",  bus.out_storedata,  e.sd);
        check_val("size",       bus.out_size,       e.size);
        check_val("regdest",    bus.out_regdest,    e.dest);
        check_val("readmem",    bus.out_readmem,    e.rdm);
        check_val("writemem",   bus.out_writemem,   e.wrm);
        check_val("writereg",   bus.out_writereg,   e.wreg);
        check_val("misaligned", bus.out_misaligned, e.mis);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic drive(input bit v, input bit rd, input bit wr, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] sd, input logic [1:0] sz,
                         input logic [4:0] dest, input bit wreg);
        bus.in_valid     = v;
        bus.in_readmem   = rd;
        bus.in_writemem  = wr;
        bus.in_base      = base;
        bus.in_offset    = off;
        bus.in_storedata = sd;
        bus.in_size      = sz;
        bus.in_regdest   = dest;
        bus.in_writereg  = wreg;
    endtask

    task automatic drive_random();
        int op;
        op = int'($urandom_range(0, 7));
        drive($urandom_range(0, 9) < 7,
              op == 1 || op == 2 || op == 7,
              op == 3 || op == 4 || op == 7,
              $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)),
              $urandom, 2'($urandom_range(0, 3)), 5'($urandom), $urandom_range(0, 1) == 1);
        bus.out_ready = $urandom_range(0, 3) != 0;
        flush         = $urandom_range(0, 31) == 0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ready_m = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        check_val("post_reset_ready", bus.in_ready, 1);

        // Word load with wrapping offset.
        drive(1, 1, 0, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0, 2'b10, 5'd3, 1);
        step();
        check_val("tp1_addr", bus.out_data_addr, 32'h0000_0FFC);
        check_val("tp1_be",   bus.out_byte_en,   4'b1111);
        check_val("tp1_mis",  bus.out_misaligned, 0);
        // Byte store to lane 3.
        drive(1, 0, 1, 32'h0000_2000, 32'h3, 32'hAB, 2'b00, 5'd0, 0);
        step();
        check_val("tp2_be", bus.out_byte_en,   4'b1000);
        check_val("tp2_sd", bus.out_storedata, 32'hAB00_0000);
        check_val("tp2_wr", bus.out_writemem,  1);
        // Misaligned half load.
        drive(1, 1, 0, 32'h0000_2000, 32'h1, 32'h0, 2'b01, 5'd7, 1);
        step();
        check_val("tp3_mis",  bus.out_misaligned, 1);
        check_val("tp3_be",   bus.out_byte_en,    4'b0000);
        check_val("tp3_rd",   bus.out_readmem,    0);
        check_val("tp3_wreg", bus.out_writereg,   0);
        check_val("tp3_addr", bus.out_data_addr,  32'h0000_2001);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Backpressure: A to main, B to skid, C refused until space frees.
        bus.out_ready = 1'b0;
        drive(1, 1, 0, 32'h100, 32'h0, 0, 2'b10, 5'd1, 1);
        step();
        drive(1, 1, 0, 32'h200, 32'h4, 0, 2'b10, 5'd2, 1);
        step();
        drive(1, 0, 1, 32'h300, 32'h8, 32'h1234, 2'b01, 5'd3, 0);
        step();
        check_val("skid_ready", bus.in_ready,      0);
        check_val("skid_head",  bus.out_data_addr, 32'h100);
        step();
        bus.out_ready = 1'b1;
        repeat (2) step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // Flush with both entries full and a pending input.
        bus.out_ready = 1'b0;
        drive(1, 1, 0, 32'h400, 32'h0, 0, 2'b00, 5'd4, 1);
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("flush_valid", bus.out_valid, 0);
        check_val("flush_ready", bus.in_ready,  1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        repeat (2) step();

        // Asynchronous reset in the middle of a cycle with data held.
        bus.out_ready = 1'b0;
        drive(1, 0, 1, 32'h500, 32'h2, 32'h55, 2'b01, 5'd5, 0);
        repeat (2) step();
        #2 reset = 1'b1;
        #1;
        q.delete();
        ready_m = 1'b0;
        check_outputs();
        step();
        reset = 1'b0;
        #1 check_val("rst_rel_ready", bus.in_ready, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        step();
        check_val("rst_edge_ready", bus.in_ready, 1);

        for (int i = 0; i < 600; i++) begin
            drive_random();
            step();
        end
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_agen_stage.md
Name: mem_agen_stage

Overview:
- Parametrised successor to the memory-stage-0 pipeline register. Sits between execute and the data-memory access stage.
- Computes the effective address (base + offset) and the per-lane byte enables from access size and low address bits. Aligns store data into its lanes and flags misaligned or illegal accesses.
- Replaces the old bubble-on-invalid register with a valid/ready handshake and a one-entry skid buffer, so downstream stalls never drop a transaction. Also adds a synchronous flush.

Parameters:
- DATA_W, 32, data path width; legal values 32 or 64. LANES = DATA_W/8; LSB_W = log2(LANES).
- ADDR_W, 32, address width; must be >= LSB_W+1.
- REG_W, 5, destination register index width.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous active-high reset.
- flush  in  1  synchronous kill of all held and incoming transactions.
- in_valid  in  1  upstream transaction present.
- in_ready  out  1  stage can accept; registered, equals ~skid_valid.
- in_readmem  in  1  load request.
- in_writemem  in  1  store request.
- in_base  in  ADDR_W  base register value.
- in_offset  in  ADDR_W  sign-extended immediate.
- in_storedata  in  DATA_W  store data, least significant bits valid.
- in_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- in_regdest  in  REG_W  destination register.
- in_writereg  in  1  writeback enable.
- out_valid  out  1  downstream transaction present.
- out_ready  in  1  downstream accepts.
- out_readmem  out  1  gated load request.
- out_writemem  out  1  gated store request.
- out_data_addr  out  ADDR_W  effective address.
- out_byte_en  out  LANES  active byte lanes.
- out_storedata  out  DATA_W  lane-aligned store data.
- out_size  out  2  size, passed through.
- out_regdest  out  REG_W  destination register, passed through.
- out_writereg  out  1  gated writeback enable.
- out_misaligned  out  1  misaligned or illegal-size access.

Behaviour:
- Reset (async, while reset=1): every output is 0, out_byte_en=0, in_ready=0, both entries empty. On the first clock edge after reset deasserts, in_ready becomes 1.
- Latency and throughput:
  - Accepted on the edge where in_valid & in_ready; visible at the outputs after that edge (1 cycle).
  - Throughput is 1 per cycle while out_ready=1.
- Address: out_data_addr = (in_base + in_offset) mod 2^ADDR_W. Carry is discarded, so wrap-around is legal.
- Size legality: 11 is illegal when DATA_W=32.
- Alignment: an access is misaligned if the low address bits are non-zero under the size mask. Half checks bit0; word checks bits1:0; dword checks bits2:0.
- Normal access (in range, aligned):
  - out_byte_en has (1<<size) consecutive ones starting at lane addr[LSB_W-1:0].
  - out_storedata = in_storedata << (8 * lane).
- Misaligned or illegal access:
  - out_misaligned=1, out_byte_en=0.
  - out_readmem, out_writemem and out_writereg forced to 0.
  - Address still reported, for the exception record.
- Non-memory op (readmem=writemem=0): passes through with byte_en=0 and misaligned=0, and writereg is preserved.
- readmem and writemem both set: treated as illegal, same handling as misaligned.
- Skid buffer, two entries (main output register and skid register):
  - A new transaction goes to main if main is empty or being consumed this cycle (out_ready & out_valid). Otherwise it goes to skid, and in_ready drops on the next cycle.
  - When main is consumed and skid is full, skid moves to main. A simultaneous new accept is impossible, because in_ready was 0.
  - No transaction is ever dropped or duplicated. Order is preserved.
- flush=1:
  - Both entries are cleared on that edge and any handshake in the same cycle is discarded.
  - Next cycle: out_valid=0, in_ready=1.
  - Flush overrides simultaneous accept and transfer.
- Outputs when out_valid=0: all payload outputs are held at 0, so downstream may sample without checking valid.

Decomposition:
- Shared package mem_pkg holds:
  - SIZE_BYTE/HALF/WORD/DWORD encodings.
  - A function computing byte enables from size and lane.
  - A function computing the misaligned flag.
  - The packed mem_req_t payload struct, reused by the next stage.
- One natural sub-module: mem_skid_buf, a generic payload-width valid/ready skid register instantiated on mem_req_t. Address and enable logic stay combinational in the parent.

Test Plan:
- DATA_W=32, base=0x1000, offset=0xFFFF_FFFC, word load, out_ready=1 -> next cycle out_valid=1, addr=0x0FFC, byte_en=1111, misaligned=0.
- Byte store, addr=0x2003, storedata=0xAB -> byte_en=1000, out_storedata=0xAB00_0000, writemem=1.
- Half load at addr=0x2001, writereg=1 -> misaligned=1, byte_en=0000, readmem=0, writereg=0, addr=0x2001.
- Three back-to-back inputs A,B,C with out_ready=0 from cycle 1 -> A held in main, B in skid, in_ready=0, C not accepted. Release out_ready -> A, B, C emerge in order with none lost.
- Main and skid full with in_valid=1, then flush=1 -> next cycle out_valid=0, in_ready=1, and no flushed transaction ever appears.
- Assert reset mid-stream, asynchronously between edges -> outputs go to 0 immediately without a clock. in_ready returns to 1 one edge after release.
